// File: rtl/jtag_dr_tx_pkg.sv
// Shared types and constants for the JTAG debug-register transmit path.
package jtag_dr_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic CH_ER1 = 1'b0;
    localparam logic CH_ER2 = 1'b1;

    // One valid-flag bit in front of the data word.
    function automatic int frame_bits(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// SYNC-deep synchroniser bank for JTAGG strobes plus a TCK rising-edge pulse in the clk domain.
module jtag_sync_edge #(
    parameter int N    = 5,
    parameter int SYNC = 3
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         tck_async,
    input  logic [N-1:0] strb_async,
    output logic [N-1:0] strb,
    output logic         tck_rise
);

    logic [N:0] pipe [SYNC];
    logic       tck_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC; i++) pipe[i] <= '0;
            tck_q <= 1'b0;
        end else begin
            pipe[0] <= {strb_async, tck_async};
            for (int i = 1; i < SYNC; i++) pipe[i] <= pipe[i-1];
            tck_q <= pipe[SYNC-1][0];
        end
    end

    assign strb     = pipe[SYNC-1][N:1];
    assign tck_rise = pipe[SYNC-1][0] & ~tck_q;

endmodule

// File: rtl/jtag_dr_tx.sv
// SoC-to-host debug-register path: two one-deep mailboxes shifted out through JTAGG ER1/ER2.
//
// state  | meaning
// IDLE   | waiting for Capture-DR on ER1 or ER2
// SHIFT  | frame captured, shifting out until Update-DR
module jtag_dr_tx
    import jtag_dr_tx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SYNC  = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_sel,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [1:0]       tx_done,
    input  logic             jtck,
    input  logic             jshift,
    input  logic             jupdate,
    input  logic             jce1,
    input  logic             jce2,
    input  logic             jrstn,
    output logic             jtdo1,
    output logic             jtdo2
);

    localparam int FRAME_BITS = frame_bits(WIDTH);
    localparam int CW         = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);

    logic                  jshift_s, jupdate_s, jce1_s, jce2_s, jrstn_s, tck_rise;
    logic [WIDTH-1:0]      mbox [2];
    logic [1:0]            full;
    state_t                state, state_nxt;
    logic                  chan, chan_nxt;
    logic [FRAME_BITS-1:0] sr, sr_nxt;
    logic [CW-1:0]         bitcnt, bitcnt_nxt;
    logic                  capv, capv_nxt;
    logic [1:0]            done_nxt;
    logic                  consume;
    logic                  jtdo1_nxt, jtdo2_nxt;
    logic                  jce_any;

    jtag_sync_edge #(.N(5), .SYNC(SYNC)) u_sync (
        .clk        (clk),
        .rstn       (rstn),
        .tck_async  (jtck),
        .strb_async ({jrstn, jce2, jce1, jupdate, jshift}),
        .strb       ({jrstn_s, jce2_s, jce1_s, jupdate_s, jshift_s}),
        .tck_rise   (tck_rise)
    );

    assign jce_any  = jce1_s | jce2_s;
    assign tx_ready = ~full[tx_sel];

    // A full mailbox refuses loads, so a consume never races a load on the same channel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full <= '0;
            for (int i = 0; i < 2; i++) mbox[i] <= '0;
        end else begin
            if (tx_valid && tx_ready) begin
                mbox[tx_sel] <= tx_data;
                full[tx_sel] <= 1'b1;
            end
            if (consume) full[chan] <= 1'b0;
        end
    end

    always_comb begin
        state_nxt  = state;
        chan_nxt   = chan;
        sr_nxt     = sr;
        bitcnt_nxt = bitcnt;
        capv_nxt   = capv;
        done_nxt   = '0;
        consume    = 1'b0;
        if (!jrstn_s) begin
            state_nxt  = ST_IDLE;
            bitcnt_nxt = '0;
        end else if (tck_rise) begin
            if (state == ST_SHIFT && jupdate_s) begin
                if (bitcnt == CNT_FULL && capv) begin
                    consume        = 1'b1;
                    done_nxt[chan] = 1'b1;
                end
                state_nxt = ST_IDLE;
            end else if (jce_any && !jshift_s) begin
                chan_nxt   = jce2_s;
                sr_nxt     = {mbox[jce2_s], full[jce2_s]};
                capv_nxt   = full[jce2_s];
                bitcnt_nxt = '0;
                state_nxt  = ST_SHIFT;
            end else if (state == ST_SHIFT && jshift_s && jce_any) begin
                sr_nxt = {1'b0, sr[FRAME_BITS-1:1]};
                if (bitcnt != CNT_FULL) bitcnt_nxt = bitcnt + CW'(1);
            end
        end
        jtdo1_nxt = sr_nxt[0] & (chan_nxt == CH_ER1) & (state_nxt == ST_SHIFT);
        jtdo2_nxt = sr_nxt[0] & (chan_nxt == CH_ER2) & (state_nxt == ST_SHIFT);
    end

    // TDO is registered from next-state values so it settles on the same clk as sr.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            chan    <= CH_ER1;
            sr      <= '0;
            bitcnt  <= '0;
            capv    <= 1'b0;
            tx_done <= '0;
            jtdo1   <= 1'b0;
            jtdo2   <= 1'b0;
        end else begin
            state   <= state_nxt;
            chan    <= chan_nxt;
            sr      <= sr_nxt;
            bitcnt  <= bitcnt_nxt;
            capv    <= capv_nxt;
            tx_done <= done_nxt;
            jtdo1   <= jtdo1_nxt;
            jtdo2   <= jtdo2_nxt;
        end
    end

endmodule
